// File: rtl/compressed_line_buffer.sv
// FIFO of completed compressed cache lines feeding the decompressor's line input.
// Optional push statistics counters enabled with `define LINE_BUF_STATS_EN.
module compressed_line_buffer #(
  parameter int CACHE_LINE = 128,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_finish_c_flag,
  input  logic                  i_stop_flag,
  input  logic [CACHE_LINE-1:0] i_compressed_word,
  input  logic                  i_compressed_flag,
  input  logic                  i_rd_req,
  output logic [CACHE_LINE-1:0] o_word_d,
  output logic                  o_compressed_flag_d,
  output logic                  o_update_d,
  output logic                  o_valid,
  output logic                  o_full,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_overflow
`ifdef LINE_BUF_STATS_EN
  ,
  output logic [15:0]           o_stat_comp,
  output logic [15:0]           o_stat_raw
`endif
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [CACHE_LINE:0] mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
  logic [ADDR_W:0]     count;
  logic                prev_stop, overflow, update;
  logic                cap, full, valid, push, pop, drop;

  // A finish right after a stop cycle closes the same line; capture it once.
  assign cap   = i_stop_flag | (i_finish_c_flag & ~prev_stop);
  assign full  = (count == FULL_COUNT);
  assign valid = (count != '0);

  always_comb begin
    pop  = i_rd_req & valid & ~i_flush;
    push = cap & ~i_flush & (~full | pop);
    drop = cap & ~i_flush & full & ~pop;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      prev_stop <= 1'b0;
      overflow  <= 1'b0;
      update    <= 1'b0;
    end else begin
      prev_stop <= i_stop_flag;
      if (i_flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        update   <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + (ADDR_W+1)'(1);
          2'b01:   count <= count - (ADDR_W+1)'(1);
          default: count <= count;
        endcase
        if (drop) overflow <= 1'b1;
        // Pop is impossible while empty, so a push from empty is the 0->1 transition.
        update <= push & ~valid;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && i_reset) mem[wr_ptr] <= {i_compressed_flag, i_compressed_word};
  end

`ifdef LINE_BUF_STATS_EN
  logic [15:0] stat_comp, stat_raw;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stat_comp <= '0;
      stat_raw  <= '0;
    end else if (i_flush) begin
      stat_comp <= '0;
      stat_raw  <= '0;
    end else if (push) begin
      if (i_compressed_flag && stat_comp != '1) stat_comp <= stat_comp + 16'd1;
      if (!i_compressed_flag && stat_raw != '1) stat_raw <= stat_raw + 16'd1;
    end
  end

  assign o_stat_comp = stat_comp;
  assign o_stat_raw  = stat_raw;
`endif

  assign o_word_d            = mem[rd_ptr][CACHE_LINE-1:0];
  assign o_compressed_flag_d = mem[rd_ptr][CACHE_LINE];
  assign o_update_d          = update;
  assign o_valid             = valid;
  assign o_full              = full;
  assign o_count             = count;
  assign o_overflow          = overflow;

endmodule

// File: tb/tb_compressed_line_buffer.sv
// Directed self-checking bench for compressed_line_buffer.
module tb_compressed_line_buffer;

  logic         clk = 1'b0;
  logic         rst_n, flush, finish, stop, cflag, rd_req;
  logic [127:0] word;
  logic [127:0] word_d;
  logic         cflag_d, update_d, valid, full, overflow;
  logic [4:0]   count;
`ifdef LINE_BUF_STATS_EN
  logic [15:0]  stat_comp, stat_raw;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  compressed_line_buffer #(.CACHE_LINE(128), .DEPTH(16), .ADDR_W(4)) dut (
    .i_clk               (clk),
    .i_reset             (rst_n),
    .i_flush             (flush),
    .i_finish_c_flag     (finish),
    .i_stop_flag         (stop),
    .i_compressed_word   (word),
    .i_compressed_flag   (cflag),
    .i_rd_req            (rd_req),
    .o_word_d            (word_d),
    .o_compressed_flag_d (cflag_d),
    .o_update_d          (update_d),
    .o_valid             (valid),
    .o_full              (full),
    .o_count             (count),
    .o_overflow          (overflow)
`ifdef LINE_BUF_STATS_EN
    ,
    .o_stat_comp         (stat_comp),
    .o_stat_raw          (stat_raw)
`endif
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [127:0] w, input logic f);
    finish = 1'b1;
    word   = w;
    cflag  = f;
    step();
    finish = 1'b0;
  endtask

  task automatic pop_line();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; finish = 1'b0; stop = 1'b0;
    cflag = 1'b0; rd_req = 1'b0; word = '0;
    #2;
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_update", update_d, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single finish pulse
    push_line({16{8'hA5}}, 1'b1);
    check("t1_valid", valid, 1);
    check("t1_word", word_d, {16{8'hA5}});
    check("t1_flag", cflag_d, 1);
    check("t1_update", update_d, 1);
    check("t1_count", count, 1);
`ifdef LINE_BUF_STATS_EN
    check("t1_stat_comp", stat_comp, 1);
    check("t1_stat_raw", stat_raw, 0);
`endif
    step();
    check("t1_update_off", update_d, 0);
    check("t1_still_valid", valid, 1);
    pop_line();
    check("t1_pop_count", count, 0);
    check("t1_pop_valid", valid, 0);
    pop_line();
    check("t1_empty_pop", count, 0);

    // stop then finish is one line
    stop = 1'b1; word = 128'h1111; cflag = 1'b0;
    step();
    stop = 1'b0; finish = 1'b1; word = 128'h2222;
    step();
    finish = 1'b0;
    check("t2_count", count, 1);
    check("t2_word", word_d, 128'h1111);
    check("t2_flag", cflag_d, 0);
    do_flush();
    check("t2_flush", count, 0);

    // two separate finishes
    push_line(128'h3, 1'b0);
    step();
    push_line(128'h4, 1'b1);
    check("t3_count", count, 2);
    check("t3_head", word_d, 128'h3);
    do_flush();

    // fill, overflow, drain in order
    for (int i = 0; i < 16; i++) push_line(128'(i), i[0]);
    check("t4_full", full, 1);
    check("t4_count", count, 16);
    check("t4_no_ovf", overflow, 0);
    push_line(128'd99, 1'b1);
    check("t4_ovf", overflow, 1);
    check("t4_ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_head%0d", i), word_d, 128'(i));
      check($sformatf("t4_flag%0d", i), cflag_d, i[0]);
      pop_line();
    end
    check("t4_drained", valid, 0);
    check("t4_ovf_sticky", overflow, 1);
    do_flush();
    check("t4_ovf_clr", overflow, 0);

    // push and pop together while full
    for (int i = 0; i < 16; i++) push_line(128'(100 + i), 1'b0);
    rd_req = 1'b1;
    push_line(128'd200, 1'b1);
    rd_req = 1'b0;
    check("t5_count", count, 16);
    check("t5_ovf", overflow, 0);
    check("t5_head", word_d, 128'd101);
    for (int i = 0; i < 15; i++) pop_line();
    check("t5_tail", word_d, 128'd200);
    check("t5_tail_flag", cflag_d, 1);
    pop_line();
    check("t5_empty", valid, 0);

    // one-deep traffic across pointer wrap
    for (int k = 0; k < 40; k++) begin
      push_line(128'(300 + k), k[1]);
      check($sformatf("t6_upd%0d", k), update_d, 1);
      check($sformatf("t6_head%0d", k), word_d, 128'(300 + k));
      pop_line();
      check($sformatf("t6_noupd%0d", k), update_d, 0);
      check($sformatf("t6_empty%0d", k), valid, 0);
    end
    push_line(128'hAAAA, 1'b0);
    check("t6_x_upd", update_d, 1);
    rd_req = 1'b1;
    push_line(128'hBBBB, 1'b1);
    rd_req = 1'b0;
    check("t6_swap_upd", update_d, 0);
    check("t6_swap_count", count, 1);
    check("t6_swap_head", word_d, 128'hBBBB);
    pop_line();

    // flush beats capture
    for (int i = 0; i < 17; i++) push_line(128'(i), 1'b0);
    for (int i = 0; i < 11; i++) pop_line();
    check("t7_pre_count", count, 5);
    check("t7_pre_ovf", overflow, 1);
    flush = 1'b1; finish = 1'b1; word = 128'h77;
    step();
    flush = 1'b0; finish = 1'b0;
    check("t7_count", count, 0);
    check("t7_valid", valid, 0);
    check("t7_ovf", overflow, 0);

    // asynchronous reset between edges
    push_line(128'h5, 1'b1);
    push_line(128'h6, 1'b1);
    check("t8_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_count", count, 0);
    check("t8_valid", valid, 0);
    check("t8_update", update_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t8_after", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
